// File: rtl/axis_i2c_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axis_i2c_master                                            |
// | Description : AXI-Stream fronted I2C master. One command beat carries    |
// |               {write bytes, addr[6:0], rw}; a read returns DATA_BYTES    |
// |               bytes on the master stream. Each SCL bit is four quarter   |
// |               ticks of MAIN_CLK/(4*I2C_CLK) clk_i cycles.                |
// | Ports       : clk_i, arstn_i (sync, active-low)                          |
// |               s_axis_tdata/tvalid/tready  - command in                   |
// |               m_axis_tdata/tvalid/tready  - read data out                |
// |               i2c_scl_o (push-pull), i2c_sda_io (open-drain style)       |
// |               busy_o, nack_o (sticky until next accepted command)        |
// | Options     : define AXIS_I2C_NACK_ABORT_EN to end a write at the first  |
// |               data-byte NACK instead of sending the remaining bytes.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axis_i2c_master #(
   parameter int MAIN_CLK   = 50_000_000,
   parameter int I2C_CLK    = 100_000,
   parameter int DATA_BYTES = 2
) (
   input  logic                      clk_i,
   input  logic                      arstn_i,
   input  logic [8*DATA_BYTES+7:0]   s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   output logic [8*DATA_BYTES-1:0]   m_axis_tdata,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      i2c_scl_o,
   inout  wire                       i2c_sda_io,
   output logic                      busy_o,
   output logic                      nack_o
);

   localparam int         c_QDIV      = MAIN_CLK / (4 * I2C_CLK);
   localparam int         c_QW        = (c_QDIV > 1) ? $clog2(c_QDIV) : 1;
   localparam int         c_WW        = 8 * DATA_BYTES;
   localparam logic [c_QW-1:0] c_QLAST = c_QW'(c_QDIV - 1);
   localparam logic [1:0] c_LAST_BYTE = 2'(DATA_BYTES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA,
      S_WACK, S_RDATA, S_RACK, S_STOP, S_RESP
   } state_t;

   state_t            r_state;
   logic [c_QW-1:0]   r_qcnt;
   logic              r_tick;
   logic [1:0]        r_q;        // quarter within the current bit
   logic [2:0]        r_bit;
   logic [1:0]        r_byte;
   logic              r_rw;
   logic [7:0]        r_sh;       // shift register for the byte on the wire
   logic [c_WW-1:0]   r_wq;       // write bytes not yet loaded into r_sh
   logic              r_ack;      // SDA level sampled in the latest Q2
   logic [c_WW-1:0]   r_rdata;
   logic              r_scl;
   logic              r_sda_oe;   // 1 = pull SDA low
   logic              r_tready;
   logic              r_tvalid;
   logic              r_busy;
   logic              r_nack;
   logic              w_sda_in;
   logic [c_WW-1:0]   w_rd_next;

   assign w_sda_in      = i2c_sda_io;
   assign i2c_sda_io    = r_sda_oe ? 1'b0 : 1'bz;
   assign i2c_scl_o     = r_scl;
   assign s_axis_tready = r_tready & arstn_i;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tdata  = r_rdata;
   assign busy_o        = r_busy;
   assign nack_o        = r_nack;

   // Received bytes enter at the top so that byte 0 ends up in the low lane.
   generate
      if (DATA_BYTES > 1) begin : g_multi_byte
         assign w_rd_next = {r_sh, r_rdata[c_WW-1:8]};
      end else begin : g_single_byte
         assign w_rd_next = r_sh;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (!arstn_i) begin
         r_state  <= S_IDLE;
         r_qcnt   <= '0;
         r_tick   <= 1'b0;
         r_q      <= 2'd0;
         r_bit    <= 3'd0;
         r_byte   <= 2'd0;
         r_rw     <= 1'b0;
         r_sh     <= 8'd0;
         r_wq     <= '0;
         r_ack    <= 1'b0;
         r_rdata  <= '0;
         r_scl    <= 1'b1;
         r_sda_oe <= 1'b0;
         r_tready <= 1'b1;
         r_tvalid <= 1'b0;
         r_busy   <= 1'b0;
         r_nack   <= 1'b0;
      end else begin
         // Tick is registered, so the first quarter after accept is one
         // clock longer than the rest.
         if (r_state == S_IDLE) begin
            r_qcnt <= '0;
            r_tick <= 1'b0;
         end else if (r_qcnt == c_QLAST) begin
            r_qcnt <= '0;
            r_tick <= 1'b1;
         end else begin
            r_qcnt <= r_qcnt + 1'b1;
            r_tick <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (s_axis_tvalid) begin
                  r_rw     <= s_axis_tdata[0];
                  r_sh     <= s_axis_tdata[7:0];
                  r_wq     <= s_axis_tdata[c_WW+7:8];
                  r_nack   <= 1'b0;
                  r_q      <= 2'd0;
                  r_bit    <= 3'd0;
                  r_byte   <= 2'd0;
                  r_sda_oe <= 1'b1;          // START: SDA falls, SCL stays high
                  r_tready <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_START;
               end
            end

            S_START: begin
               if (r_tick) begin
                  r_q <= r_q + 2'd1;
                  if (r_q == 2'd1) r_scl <= 1'b0;
                  if (r_q == 2'd3) begin
                     r_sda_oe <= ~r_sh[7];
                     r_state  <= S_ADDR;
                  end
               end
            end

            S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_RACK: begin
               if (r_tick) begin
                  r_q <= r_q + 2'd1;
                  case (r_q)
                     2'd0: r_scl <= 1'b1;
                     2'd2: begin
                        r_scl <= 1'b0;
                        r_ack <= w_sda_in;
                        if (r_state == S_RDATA) r_sh <= {r_sh[6:0], w_sda_in};
                     end
                     2'd3: begin
                        // End of bit: choose what the next Q0 puts on SDA.
                        case (r_state)
                           S_ADDR, S_WDATA: begin
                              if (r_bit == 3'd7) begin
                                 r_bit    <= 3'd0;
                                 r_sda_oe <= 1'b0;
                                 r_state  <= (r_state == S_ADDR) ? S_ADDR_ACK : S_WACK;
                              end else begin
                                 r_bit    <= r_bit + 3'd1;
                                 r_sh     <= {r_sh[6:0], 1'b0};
                                 r_sda_oe <= ~r_sh[6];
                              end
                           end
                           S_ADDR_ACK: begin
                              if (r_ack) begin
                                 r_nack   <= 1'b1;
                                 if (r_rw) r_rdata <= '1;
                                 r_sda_oe <= 1'b1;
                                 r_state  <= S_STOP;
                              end else if (!r_rw) begin
                                 r_sh     <= r_wq[7:0];
                                 r_sda_oe <= ~r_wq[7];
                                 r_wq     <= r_wq >> 8;
                                 r_state  <= S_WDATA;
                              end else begin
                                 r_sda_oe <= 1'b0;
                                 r_state  <= S_RDATA;
                              end
                           end
                           S_WACK: begin
                              if (r_ack) r_nack <= 1'b1;
`ifdef AXIS_I2C_NACK_ABORT_EN
                              if (r_ack || (r_byte == c_LAST_BYTE)) begin
`else
                              if (r_byte == c_LAST_BYTE) begin
`endif
                                 r_sda_oe <= 1'b1;
                                 r_state  <= S_STOP;
                              end else begin
                                 r_byte   <= r_byte + 2'd1;
                                 r_sh     <= r_wq[7:0];
                                 r_sda_oe <= ~r_wq[7];
                                 r_wq     <= r_wq >> 8;
                                 r_state  <= S_WDATA;
                              end
                           end
                           S_RDATA: begin
                              if (r_bit == 3'd7) begin
                                 r_bit    <= 3'd0;
                                 r_rdata  <= w_rd_next;
                                 // ACK every byte but the last one
                                 r_sda_oe <= (r_byte != c_LAST_BYTE);
                                 r_state  <= S_RACK;
                              end else begin
                                 r_bit <= r_bit + 3'd1;
                              end
                           end
                           default: begin   // S_RACK
                              if (r_byte == c_LAST_BYTE) begin
                                 r_sda_oe <= 1'b1;
                                 r_state  <= S_STOP;
                              end else begin
                                 r_byte   <= r_byte + 2'd1;
                                 r_sda_oe <= 1'b0;
                                 r_state  <= S_RDATA;
                              end
                           end
                        endcase
                     end
                     default: ;
                  endcase
               end
            end

            S_STOP: begin
               // Entered with SCL low and SDA low; three quarters only.
               if (r_tick) begin
                  r_q <= r_q + 2'd1;
                  if (r_q == 2'd0) r_scl <= 1'b1;
                  if (r_q == 2'd1) r_sda_oe <= 1'b0;
                  if (r_q == 2'd2) begin
                     r_q <= 2'd0;
                     if (r_rw) begin
                        r_tvalid <= 1'b1;
                        r_state  <= S_RESP;
                     end else begin
                        r_busy   <= 1'b0;
                        r_tready <= 1'b1;
                        r_qcnt   <= '0;
                        r_tick   <= 1'b0;
                        r_state  <= S_IDLE;
                     end
                  end
               end
            end

            S_RESP: begin
               if (m_axis_tready) begin
                  r_tvalid <= 1'b0;
                  r_busy   <= 1'b0;
                  r_tready <= 1'b1;
                  r_qcnt   <= '0;
                  r_tick   <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_i2c_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_axis_i2c_master                                         |
// | Description : Bench for axis_i2c_master with a bus-level I2C slave       |
// |               model decoding START/STOP/bits from SCL/SDA.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_axis_i2c_master;

   localparam int DB   = 2;
   localparam int QDIV = 1;
   typedef logic [8*DB-1:0] wd_t;

   logic            clk = 1'b0;
   logic            arstn = 1'b0;
   logic [8*DB+7:0] s_tdata = '0;
   logic            s_tvalid = 1'b0;
   logic            s_tready;
   wd_t             m_tdata;
   logic            m_tvalid;
   logic            m_tready = 1'b0;
   logic            scl;
   wire             sda;
   logic            busy;
   logic            nack;

   logic            sl_low = 1'b0;
   pullup (sda);
   assign sda = sl_low ? 1'b0 : 1'bz;

   int n_total = 0;
   int n_bad   = 0;

   axis_i2c_master #(
      .MAIN_CLK  (400_000),
      .I2C_CLK   (100_000),
      .DATA_BYTES(DB)
   ) dut (
      .clk_i        (clk),
      .arstn_i      (arstn),
      .s_axis_tdata (s_tdata),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .m_axis_tdata (m_tdata),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .i2c_scl_o    (scl),
      .i2c_sda_io   (sda),
      .busy_o       (busy),
      .nack_o       (nack)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- slave policy and bus record ----------------
   logic       pol_addr_nack = 1'b0;
   logic       pol_wnack [4];
   logic [7:0] pol_rbytes[4];
   logic [7:0] rec_bytes[$];
   logic       rec_acks[$];    // 9th bit after each master-sent byte
   logic       rec_macks[$];   // master's answer after each read byte
   int         rec_starts = 0;
   int         rec_stops  = 0;
   int         sl_bitcnt  = 0;
   int         sl_byte    = 0;

   initial begin
      logic p_scl, p_sda, rise_seen, rw, reading;
      logic [7:0] cur;
      p_scl = 1'b1; p_sda = 1'b1; rise_seen = 1'b0; rw = 1'b0; reading = 1'b0; cur = 8'd0;
      forever begin
         @(negedge clk);
         if (!arstn) begin
            sl_low = 1'b0; sl_bitcnt = 0; sl_byte = 0; rise_seen = 1'b0;
            reading = 1'b0; p_scl = 1'b1; p_sda = 1'b1;
         end else begin
            if (p_scl && scl && p_sda && !sda) begin
               rec_starts++;
               sl_bitcnt = 0; sl_byte = 0; rise_seen = 1'b0; rw = 1'b0; reading = 1'b0; sl_low = 1'b0;
            end else if (p_scl && scl && !p_sda && sda) begin
               rec_stops++;
               reading = 1'b0; sl_low = 1'b0;
            end else if (!p_scl && scl) begin
               rise_seen = 1'b1;
               if (sl_bitcnt < 8) cur = {cur[6:0], sda};
               else if (sl_byte == 0 || !rw) rec_acks.push_back(sda);
               else begin
                  rec_macks.push_back(sda);
                  if (sda) reading = 1'b0;
               end
            end else if (p_scl && !scl && rise_seen) begin
               rise_seen = 1'b0;
               if (sl_bitcnt < 8) begin
                  sl_bitcnt++;
                  if (sl_bitcnt == 8) begin
                     if (sl_byte == 0) begin
                        rec_bytes.push_back(cur);
                        rw      = cur[0];
                        reading = cur[0] && !pol_addr_nack;
                        sl_low  = !pol_addr_nack;
                     end else if (!rw) begin
                        rec_bytes.push_back(cur);
                        sl_low = (sl_byte <= 4) ? !pol_wnack[sl_byte-1] : 1'b0;
                     end else begin
                        sl_low = 1'b0;
                     end
                  end else if (reading && sl_byte > 0 && sl_byte <= 4) begin
                     sl_low = !pol_rbytes[sl_byte-1][7-sl_bitcnt];
                  end
               end else begin
                  sl_bitcnt = 0;
                  sl_byte++;
                  if (reading && sl_byte <= 4) sl_low = !pol_rbytes[sl_byte-1][7];
                  else sl_low = 1'b0;
               end
            end
            p_scl = scl;
            p_sda = sda;
         end
      end
   end

   // One command end to end; expectations come from the I2C framing rules.
   task automatic run_cmd(input logic [6:0] addr, input logic rw, input wd_t wdata, input int rdly);
      int   first_nack, exp_nbytes, exp_cyc, cyc;
      logic exp_nack, hold_ok;
      wd_t  exp_rd, held;
      first_nack = -1;
      for (int k = 0; k < DB; k++) if (pol_wnack[k] && first_nack < 0) first_nack = k;
      exp_nack = pol_addr_nack || (!rw && first_nack >= 0);
      if (pol_addr_nack || rw) exp_nbytes = 1;
      else begin
`ifdef AXIS_I2C_NACK_ABORT_EN
         exp_nbytes = (first_nack >= 0) ? first_nack + 2 : DB + 1;
`else
         exp_nbytes = DB + 1;
`endif
      end
      // START 4 + address/ack 36 + 36 per data byte + STOP 3 quarters,
      // plus one clock before the first quarter tick.
      exp_cyc = 1 + QDIV * (4 + 36 + (pol_addr_nack ? 0 : (rw ? DB : exp_nbytes - 1) * 36) + 3);
      for (int k = 0; k < DB; k++) exp_rd[8*k +: 8] = pol_rbytes[k];
      if (pol_addr_nack) exp_rd = '1;

      rec_bytes.delete(); rec_acks.delete(); rec_macks.delete();
      rec_starts = 0; rec_stops = 0;
      @(negedge clk);
      check_eq("rdy_idle", s_tready, 1);
      s_tdata  = {wdata, addr, rw};
      s_tvalid = 1'b1;
      @(posedge clk);
      #1 s_tvalid = 1'b0;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!busy || m_tvalid || cyc > 4000) break;
         cyc++;
      end
      check_eq("cycles", cyc, exp_cyc);
      check_eq("nack", nack, exp_nack);
      check_eq("starts", rec_starts, 1);
      check_eq("stops", rec_stops, 1);
      check_eq("nbytes", rec_bytes.size(), exp_nbytes);
      for (int k = 0; k < rec_bytes.size() && k < exp_nbytes; k++)
         check_eq("byte", rec_bytes[k], (k == 0) ? {addr, rw} : wdata[8*(k-1) +: 8]);
      check_eq("nacks", rec_acks.size(), exp_nbytes);
      for (int k = 0; k < rec_acks.size() && k < exp_nbytes; k++)
         check_eq("ackbit", rec_acks[k], (k == 0) ? pol_addr_nack : pol_wnack[k-1]);
      check_eq("nmacks", rec_macks.size(), (rw && !pol_addr_nack) ? DB : 0);
      for (int k = 0; k < rec_macks.size() && k < DB; k++)
         check_eq("mack", rec_macks[k], (k == DB - 1));
      if (rw) begin
         check_eq("rvalid", m_tvalid, 1);
         held    = m_tdata;
         hold_ok = 1'b1;
         repeat (rdly) begin
            @(negedge clk);
            if (!m_tvalid || m_tdata !== held || !busy) hold_ok = 1'b0;
         end
         check_eq("rhold", hold_ok, 1);
         check_eq("rdata", held, exp_rd);
         check_eq("nack_resp", nack, exp_nack);
         m_tready = 1'b1;
         @(posedge clk);
         #1 m_tready = 1'b0;
         @(negedge clk);
      end
      check_eq("vld_low", m_tvalid, 0);
      check_eq("busy_end", busy, 0);
   endtask

   task automatic clear_policy();
      pol_addr_nack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pol_wnack[k]  = 1'b0;
         pol_rbytes[k] = 8'hFF;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: run did not end, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      clear_policy();
      repeat (3) @(posedge clk);
      #1 arstn = 1'b1;
      @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rdy", s_tready, 1);
      check_eq("rst_vld", m_tvalid, 0);
      check_eq("rst_nack", nack, 0);
      check_eq("rst_scl", scl, 1);
      check_eq("rst_sda", sda, 1);
      check_eq("rst_rdata", m_tdata, 0);

      // write 0xBEEF to 0x50, all ACKed
      run_cmd(7'h50, 1'b0, 16'hBEEF, 0);
      // read 0x12, 0x34 with the consumer stalling 5 cycles
      pol_rbytes[0] = 8'h12; pol_rbytes[1] = 8'h34;
      run_cmd(7'h50, 1'b1, '0, 5);
      // address NACK, write then read
      clear_policy(); pol_addr_nack = 1'b1;
      run_cmd(7'h3C, 1'b0, 16'h5AA5, 0);
      run_cmd(7'h3C, 1'b1, '0, 2);
      // data NACK on byte 0
      clear_policy(); pol_wnack[0] = 1'b1;
      run_cmd(7'h21, 1'b0, 16'hC381, 0);

      // reset during bit 3 of the first data byte
      clear_policy();
      @(negedge clk);
      s_tdata  = {16'h1234, 7'h2A, 1'b0};
      s_tvalid = 1'b1;
      @(posedge clk);
      #1 s_tvalid = 1'b0;
      n = 0;
      while (!(sl_byte == 1 && sl_bitcnt == 3) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq("rst_reach", (n < 500), 1);
      arstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_eq("mid_scl", scl, 1);
      check_eq("mid_sda", sda, 1);
      check_eq("mid_busy", busy, 0);
      #2 arstn = 1'b1;
      #1 check_eq("mid_rdy", s_tready, 1);
      run_cmd(7'h2A, 1'b0, 16'h1234, 0);

      // randomized commands and slave behaviour
      for (int t = 0; t < 24; t++) begin
         pol_addr_nack = ($urandom_range(0, 4) == 0);
         for (int k = 0; k < 4; k++) begin
            pol_wnack[k]  = ($urandom_range(0, 3) == 0);
            pol_rbytes[k] = 8'($urandom);
         end
         run_cmd(7'($urandom), 1'($urandom), wd_t'($urandom), $urandom_range(0, 5));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axis_i2c_master.md
AXIS_I2C_MASTER -- requirements
Module: axis_i2c_master

Interface
REQ-001 SHALL have parameter MAIN_CLK, default 50_000_000, meaning clk_i frequency in Hz.
REQ-002 SHALL have parameter I2C_CLK, default 100_000, meaning SCL frequency in Hz; QDIV = MAIN_CLK/(4*I2C_CLK) SHALL be >= 1.
REQ-003 SHALL have parameter DATA_BYTES, default 2, range 1..4, meaning data bytes per transaction.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all logic is in this domain.
REQ-005 SHALL have port arstn_i, input, 1, meaning the reset: synchronous, active-low.
REQ-006 SHALL have port s_axis_tdata, input, 8+8*DATA_BYTES, meaning command: [7:1] address, [0] rw (1 = read), [8*k+15:8*k+8] write byte k.
REQ-007 SHALL have ports s_axis_tvalid (input, 1) and s_axis_tready (output, 1), meaning command handshake.
REQ-008 SHALL have port m_axis_tdata, output, 8*DATA_BYTES, meaning read data; byte k is in [8*k+7:8*k].
REQ-009 SHALL have ports m_axis_tvalid (output, 1) and m_axis_tready (input, 1), meaning read-data handshake.
REQ-010 SHALL have port i2c_scl_o, output, 1, meaning SCL, driven push-pull.
REQ-011 SHALL have port i2c_sda_io, inout, 1, meaning SDA: driven low for 0, released to 'z' for 1, sampled as input.
REQ-012 SHALL have ports busy_o (output, 1, transaction in progress) and nack_o (output, 1, sticky NACK flag).

Function
REQ-013 A quarter-tick counter SHALL pulse every QDIV cycles while busy and hold at 0 in IDLE.
REQ-014 Each bit SHALL take 4 quarters: Q0 SCL low and SDA updated; Q1 SCL high; Q2 SCL high and SDA sampled; Q3 SCL low.
REQ-015 States SHALL be IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP, RESP.
REQ-016 IDLE: s_axis_tready=1, SCL=1, SDA released; s_axis_tvalid&tready SHALL latch the command, clear nack_o, and go to START.
REQ-017 START: SDA falls while SCL=1 (two quarters), then SCL falls (two quarters); then ADDR.
REQ-018 ADDR SHALL shift out {addr,rw} MSB first over 8 bits; ADDR_ACK releases SDA and samples ACK at Q2.
REQ-019 After ADDR ACK: rw=0 -> WDATA with byte 0; rw=1 -> RDATA; an ADDR NACK SHALL set nack_o and go to STOP.
REQ-020 WDATA/WACK SHALL send bytes 0..DATA_BYTES-1 MSB first, sampling ACK after each byte; STOP follows the last byte.
REQ-021 RDATA SHALL shift in 8 bits MSB first; RACK SHALL drive ACK (SDA low) after every byte except the last, which gets NACK (SDA released).
REQ-022 STOP: SDA low with SCL low, SCL rises, then SDA released while SCL=1, one quarter each; then RESP if rw=1, else IDLE.
REQ-023 RESP: m_axis_tvalid=1 with assembled data, held stable until m_axis_tready=1, then IDLE; m_axis_tvalid SHALL be 0 in all other states.
REQ-024 A read after an ADDR NACK SHALL still pass through RESP, with m_axis_tdata all ones and nack_o=1.
REQ-025 busy_o SHALL be 1 in every state except IDLE; s_axis_tready SHALL be 0 whenever busy_o=1.
REQ-026 nack_o SHALL remain set until the next command is accepted.

Reset
REQ-027 On arstn_i=0 at a clk_i edge: state IDLE, tick counter 0, SCL=1, SDA released, s_axis_tready=1 once arstn_i=1.
REQ-028 Reset SHALL also set m_axis_tvalid=0, busy_o=0, nack_o=0 and m_axis_tdata=0.
REQ-029 Reset mid-transaction SHALL abandon the transfer with no STOP generated; SDA is released and SCL=1 on the next cycle.

Configuration
REQ-030 Macro AXIS_I2C_NACK_ABORT_EN defined: a data-byte NACK in WACK SHALL set nack_o and go directly to STOP.
REQ-031 Macro AXIS_I2C_NACK_ABORT_EN undefined: a data-byte NACK SHALL set nack_o, and all remaining bytes SHALL still be sent before STOP.

Verification
REQ-032 Write scenario: QDIV=1, DATA_BYTES=2, slave ACKs all, command 0xBEEF_A0 -> SDA shows START, 0xA0, ACK, 0xEF, ACK, 0xBE, ACK, STOP; nack_o=0; 116 cycles from accept to IDLE.
REQ-033 Read scenario: command 0x0000_A1, slave returns 0x12 then 0x34 -> master ACKs byte 0 and NACKs byte 1; m_axis_tdata=0x3412 held while m_axis_tready is held low for 5 cycles.
REQ-034 Address NACK: slave leaves SDA high at ADDR_ACK -> STOP immediately after, nack_o=1, no data bytes clocked.
REQ-035 Data NACK on byte 0 of a write: with AXIS_I2C_NACK_ABORT_EN -> STOP after byte 0; without it -> byte 1 is still sent; nack_o=1 in both cases.
REQ-036 Reset during bit 3 of WDATA -> next cycle SCL=1, SDA='z', busy_o=0, s_axis_tready=1; a new command then completes normally.
